reservation_price: RTL
======================

Name: reservation_price

Overview:
Downstream stage of the volatility block. Consumes per-stock variance (o_volatility) and mid price (o_curr_price), tracks signed inventory per stock from fill reports, and produces the Avellaneda-Stoikov reservation price r = s − q·γ·σ²·(T−t). Fully pipelined, one result per cycle, and feeds the spread/quote generator.

Parameters:
DATA_WIDTH, 32, price, quantity and inventory width.
NUM_STOCKS, 4, number of tracked stocks.
FP_WORD_SIZE, 64, fixed-point word width, unsigned Q32.32.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_data_valid  in  1  market sample valid, from volatility o_data_valid
i_stock_id  in  $clog2(NUM_STOCKS)  stock of market sample
i_volatility  in  FP_WORD_SIZE  σ², Q32.32
i_curr_price  in  DATA_WIDTH  mid price s, unsigned ticks
i_gamma  in  FP_WORD_SIZE  risk aversion γ, Q32.32, quasi-static
i_time_remaining  in  FP_WORD_SIZE  (T−t), Q32.32, quasi-static
i_fill_valid  in  1  fill report valid
i_fill_stock_id  in  $clog2(NUM_STOCKS)  filled stock
i_fill_side  in  1  0 = we bought (q+=qty), 1 = we sold (q−=qty)
i_fill_qty  in  DATA_WIDTH  fill quantity, unsigned
o_data_valid  out  1  result valid
o_stock_id  out  $clog2(NUM_STOCKS)  stock of result
o_reservation_price  out  DATA_WIDTH  r, unsigned ticks
o_inventory  out  DATA_WIDTH  signed q used for this result

Behaviour:
- Reset (async assert, sync release): all outputs 0, all pipeline valids 0, all inventories 0. Asserting reset mid-operation drops in-flight samples. No output appears for them.
- Inventory: NUM_STOCKS signed registers. Updated on the cycle after i_fill_valid. Saturate at ±(2^(DATA_WIDTH−1)−1) and never wrap.
- Pipeline: 5 stages, latency 5. A sample accepted at edge N appears with o_data_valid at edge N+5. There is no backpressure and no stall. A new sample is accepted every cycle.
- S1: register the sample and read q[stock]. Bypass rule: a fill and a sample for the same stock in the same cycle use the post-fill q.
- S2: A = γ·σ². Take the 128-bit product bits [95:32]. If bits [127:96] ≠ 0, saturate to 2^64−1.
- S3: B = A·(T−t), same rule as S2.
- S4: adj = (B·|q| + 2^31) >> 32. This is round-half-up. Saturate to 2^DATA_WIDTH−1.
- S5: r = s − adj for q > 0, s + adj for q < 0, s for q = 0. Clamp to [0, 2^DATA_WIDTH−1].
- o_inventory and o_stock_id travel with the sample.
- γ and T−t are sampled in S1 and carried with the sample, so a mid-flight change does not corrupt in-flight results.
- When o_data_valid = 0, outputs hold their last values.

Decomposition:
- Package reservation_price_pkg holds:
  - Q32.32 constants FP_ONE and FP_HALF_LSB.
  - Typedefs: fxp_t (FP_WORD_SIZE), price_t, inv_t (signed DATA_WIDTH), stock_id_t.
  - Saturation functions sat_u64 and sat_inv.
- Sub-module fxp_mul_sat: Q32.32 × Q32.32 → Q32.32 with saturation, 1 cycle registered. Instantiated in S2 and S3.

Test Plan:
- γ=0.5 (0x0000_0000_8000_0000), σ²=4.0 (0x4_0000_0000), T−t=1.0 (0x1_0000_0000), s=1000. Three buy fills of qty 1 on stock 1, then a sample → r=994, o_inventory=3, exactly 5 cycles after i_data_valid.
- Same config, stock 2 with two sell fills of qty 1 → r=1004, o_inventory=−2. Stock 0 with no fills → r=1000.
- Same-cycle fill (buy qty 5, stock 3) and sample (stock 3, s=100) → q=5, adj=10, r=90.
- Clamp: s=5, q=10 → adj=20, r=0. σ²=2^63 with γ=4.0 → S2 saturates and r=0 for q>0.
- Back-to-back samples on stocks 0,1,2,3 over 4 consecutive cycles → 4 consecutive valid results in order with correct ids. Then assert i_reset_n low mid-pipeline → o_data_valid=0 immediately, no late results, and all inventories read 0 afterwards.

Source files
------------

// File: rtl/reservation_price_pkg.sv
// rtl/reservation_price_pkg.sv - shared types, Q32.32 constants and saturation helpers for reservation_price
package reservation_price_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_STOCKS   = 4;
    localparam int FP_WORD_SIZE = 64;
    localparam int FRAC_BITS    = 32;
    localparam int SID_W        = $clog2(NUM_STOCKS);

    typedef logic [FP_WORD_SIZE-1:0]      fxp_t;
    typedef logic [DATA_WIDTH-1:0]        price_t;
    typedef logic signed [DATA_WIDTH-1:0] inv_t;
    typedef logic [SID_W-1:0]             stock_id_t;

    localparam fxp_t FP_ONE      = fxp_t'(1) << FRAC_BITS;
    localparam fxp_t FP_HALF_LSB = fxp_t'(1) << (FRAC_BITS - 1);

    // Symmetric inventory limit, so |q| always fits in DATA_WIDTH-1 bits
    localparam longint INV_MAX_L = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;

    function automatic fxp_t sat_u64(input logic [2*FP_WORD_SIZE-1:0] p);
        if (p[2*FP_WORD_SIZE-1:FP_WORD_SIZE+FRAC_BITS] != '0) begin
            return '1;
        end
        return p[FP_WORD_SIZE+FRAC_BITS-1:FRAC_BITS];
    endfunction

    function automatic inv_t sat_inv(input logic signed [DATA_WIDTH+1:0] v);
        if (v > INV_MAX_L) begin
            return inv_t'(INV_MAX_L);
        end
        if (v < -INV_MAX_L) begin
            return inv_t'(-INV_MAX_L);
        end
        return inv_t'(v);
    endfunction

endpackage

// File: rtl/reservation_price_fxp_mul_sat.sv
// rtl/reservation_price_fxp_mul_sat.sv - registered Q32.32 x Q32.32 multiply with saturation to all-ones
module fxp_mul_sat
    import reservation_price_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  fxp_t a_i,
    input  fxp_t b_i,
    output fxp_t p_o
);

    logic [2*FP_WORD_SIZE-1:0] prod;
    fxp_t p_d;
    fxp_t p_q;

    assign prod = {{FP_WORD_SIZE{1'b0}}, a_i} * {{FP_WORD_SIZE{1'b0}}, b_i};
    assign p_d  = sat_u64(prod);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/reservation_price.sv
// rtl/reservation_price.sv - 5-stage Avellaneda-Stoikov reservation price r = s - q*gamma*sigma^2*(T-t)
module reservation_price #(
    parameter int DATA_WIDTH   = reservation_price_pkg::DATA_WIDTH,
    parameter int NUM_STOCKS   = reservation_price_pkg::NUM_STOCKS,
    parameter int FP_WORD_SIZE = reservation_price_pkg::FP_WORD_SIZE
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_data_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [FP_WORD_SIZE-1:0]       i_volatility,
    input  logic [DATA_WIDTH-1:0]         i_curr_price,
    input  logic [FP_WORD_SIZE-1:0]       i_gamma,
    input  logic [FP_WORD_SIZE-1:0]       i_time_remaining,
    input  logic                          i_fill_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock_id,
    input  logic                          i_fill_side,
    input  logic [DATA_WIDTH-1:0]         i_fill_qty,
    output logic                          o_data_valid,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_reservation_price,
    output logic [DATA_WIDTH-1:0]         o_inventory
);
    import reservation_price_pkg::*;

    localparam int PW = FP_WORD_SIZE + DATA_WIDTH + 1;

    inv_t inv_q [NUM_STOCKS];
    inv_t inv_d [NUM_STOCKS];
    inv_t fill_cur, fill_new;
    logic signed [DATA_WIDTH+1:0] fill_base, fill_qty_w;

    assign fill_cur   = inv_q[i_fill_stock_id];
    assign fill_base  = {{2{fill_cur[DATA_WIDTH-1]}}, fill_cur};
    assign fill_qty_w = {2'b00, i_fill_qty};
    assign fill_new   = i_fill_side ? sat_inv(fill_base - fill_qty_w)
                                    : sat_inv(fill_base + fill_qty_w);

    // inv_d doubles as the same-cycle bypass for the sample read in S1
    always_comb begin
        for (int i = 0; i < NUM_STOCKS; i++) begin
            inv_d[i] = inv_q[i];
            if (i_fill_valid && (i_fill_stock_id == stock_id_t'(i))) begin
                inv_d[i] = fill_new;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                inv_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    logic      v1_q, v2_q, v3_q, v4_q;
    stock_id_t id1_q, id2_q, id3_q, id4_q;
    price_t    s1_q, s2_q, s3_q, s4_q;
    inv_t      q1_q, q2_q, q3_q, q4_q;
    fxp_t      g1_q, sig1_q, tr1_q, tr2_q;
    fxp_t      a2, b3;
    price_t    adj4_q, adj4_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            v1_q  <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
            id1_q <= '0; id2_q <= '0; id3_q <= '0; id4_q <= '0;
            s1_q  <= '0; s2_q  <= '0; s3_q  <= '0; s4_q  <= '0;
            q1_q  <= '0; q2_q  <= '0; q3_q  <= '0; q4_q  <= '0;
            g1_q  <= '0; sig1_q <= '0; tr1_q <= '0; tr2_q <= '0;
            adj4_q <= '0;
        end else begin
            v1_q <= i_data_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (i_data_valid) begin
                id1_q  <= i_stock_id;
                s1_q   <= i_curr_price;
                q1_q   <= inv_d[i_stock_id];
                g1_q   <= i_gamma;
                sig1_q <= i_volatility;
                tr1_q  <= i_time_remaining;
            end
            if (v1_q) begin
                id2_q <= id1_q; s2_q <= s1_q; q2_q <= q1_q; tr2_q <= tr1_q;
            end
            if (v2_q) begin
                id3_q <= id2_q; s3_q <= s2_q; q3_q <= q2_q;
            end
            if (v3_q) begin
                id4_q <= id3_q; s4_q <= s3_q; q4_q <= q3_q; adj4_q <= adj4_d;
            end
        end
    end

    fxp_mul_sat u_mul_a (.clk_i(i_clk), .rst_ni(i_reset_n), .a_i(g1_q), .b_i(sig1_q), .p_o(a2));
    fxp_mul_sat u_mul_b (.clk_i(i_clk), .rst_ni(i_reset_n), .a_i(a2),   .b_i(tr2_q),  .p_o(b3));

    price_t        q_mag;
    logic [PW-1:0] adj_sum, adj_shift;

    assign q_mag     = q3_q[DATA_WIDTH-1] ? price_t'(-q3_q) : price_t'(q3_q);
    assign adj_sum   = ({{(DATA_WIDTH+1){1'b0}}, b3} * {{(FP_WORD_SIZE+1){1'b0}}, q_mag})
                       + PW'(FP_HALF_LSB);
    assign adj_shift = adj_sum >> FRAC_BITS;
    assign adj4_d    = (adj_shift[PW-1:DATA_WIDTH] != '0) ? '1 : adj_shift[DATA_WIDTH-1:0];

    logic [DATA_WIDTH:0] r_sub, r_add;
    price_t              r_d;

    assign r_sub = {1'b0, s4_q} - {1'b0, adj4_q};
    assign r_add = {1'b0, s4_q} + {1'b0, adj4_q};

    always_comb begin
        r_d = s4_q;
        if (q4_q[DATA_WIDTH-1]) begin
            r_d = r_add[DATA_WIDTH] ? '1 : r_add[DATA_WIDTH-1:0];
        end else if (q4_q != '0) begin
            r_d = r_sub[DATA_WIDTH] ? '0 : r_sub[DATA_WIDTH-1:0];
        end
    end

    logic      out_v_q;
    stock_id_t out_id_q;
    price_t    out_r_q;
    inv_t      out_q_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_v_q  <= 1'b0;
            out_id_q <= '0;
            out_r_q  <= '0;
            out_q_q  <= '0;
        end else begin
            out_v_q <= v4_q;
            if (v4_q) begin
                out_id_q <= id4_q;
                out_r_q  <= r_d;
                out_q_q  <= q4_q;
            end
        end
    end

    assign o_data_valid        = out_v_q;
    assign o_stock_id          = out_id_q;
    assign o_reservation_price = out_r_q;
    assign o_inventory         = out_q_q;

endmodule
